// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the keccak byte packer.
package keccak_pkg;
  localparam int KECCAK_WORD_W = 32;
  localparam int KECCAK_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WAIT  = 2'd3
  } packer_state_e;

  // Lane 0 is the most significant byte, matching the core's byte order.
  function automatic logic [KECCAK_WORD_W-1:0] lane_insert(
    input logic [KECCAK_WORD_W-1:0] word,
    input logic [1:0]               lane,
    input logic [7:0]               data
  );
    logic [KECCAK_WORD_W-1:0] res;
    res = word;
    case (lane)
      2'd0:    res[31:24] = data;
      2'd1:    res[23:16] = data;
      2'd2:    res[15:8]  = data;
      2'd3:    res[7:0]   = data;
      default: res        = word;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/keccak_word_slot.sv
// One-entry output register toward the keccak core; may reload in the cycle it drains.
module keccak_word_slot
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [KECCAK_WORD_W-1:0] load_data,
  input  logic                     load_last,
  input  logic [1:0]               load_bnum,
  input  logic                     buffer_full,
  output logic                     can_load,
  output logic                     accept,
  output logic                     valid,
  output logic [KECCAK_WORD_W-1:0] data,
  output logic                     last,
  output logic [1:0]               bnum
);
  logic                     valid_r;
  logic [KECCAK_WORD_W-1:0] data_r;
  logic                     last_r;
  logic [1:0]               bnum_r;

  assign accept   = valid_r & ~buffer_full;
  assign can_load = ~valid_r | accept;
  assign valid    = valid_r;
  assign data     = data_r;
  assign last     = last_r;
  assign bnum     = bnum_r;

  // Slot contents: load wins over drain, drained slot reads back as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      last_r  <= 1'b0;
      bnum_r  <= 2'd0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      last_r  <= load_last;
      bnum_r  <= load_bnum;
    end else if (accept) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      last_r  <= 1'b0;
      bnum_r  <= 2'd0;
    end
  end
endmodule

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream into 32-bit keccak core words, adding the empty pad word on word-aligned ends.
// Optional msg_bytes counter enabled by defining KECCAK_PACKER_LEN_EN.
module keccak_byte_packer
  import keccak_pkg::*;
#(
  parameter bit WAIT_DIGEST = 1'b1
`ifdef KECCAK_PACKER_LEN_EN
  ,
  parameter int LEN_W       = 32
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [KECCAK_WORD_W-1:0] k_in,
  output logic                     k_in_ready,
  output logic                     k_is_last,
  output logic [1:0]               k_byte_num,
  input  logic                     k_buffer_full,
  input  logic                     k_out_ready,
  output logic                     busy
`ifdef KECCAK_PACKER_LEN_EN
  ,
  output logic [LEN_W-1:0]         msg_bytes
`endif
);
  packer_state_e            state_r, state_nxt;
  logic [1:0]               cnt_r, cnt_nxt;
  logic [KECCAK_WORD_W-1:0] asm_r, asm_nxt;
  logic [KECCAK_WORD_W-1:0] word_s;
  logic                     load_s, load_last_s, len_clr_s, s_ready_s, fire_s;
  logic [KECCAK_WORD_W-1:0] load_data_s;
  logic [1:0]               load_bnum_s;
  logic                     slot_can_load_s, slot_accept_s;

  keccak_word_slot u_slot (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .load_data   (load_data_s),
    .load_last   (load_last_s),
    .load_bnum   (load_bnum_s),
    .buffer_full (k_buffer_full),
    .can_load    (slot_can_load_s),
    .accept      (slot_accept_s),
    .valid       (k_in_ready),
    .data        (k_in),
    .last        (k_is_last),
    .bnum        (k_byte_num)
  );

  assign s_ready = s_ready_s & ~reset;
  assign fire_s  = s_valid & s_ready_s;
  assign busy    = (state_r != ST_FILL) | (cnt_r != 2'd0);

  // State, lane counter and partial-word assembly register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FILL;
      cnt_r   <= 2'd0;
      asm_r   <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      asm_r   <= asm_nxt;
    end
  end

  // Next-state, byte packing and slot load decisions.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    asm_nxt     = asm_r;
    load_s      = 1'b0;
    load_data_s = '0;
    load_last_s = 1'b0;
    load_bnum_s = 2'd0;
    len_clr_s   = 1'b0;
    s_ready_s   = 1'b0;
    word_s      = lane_insert(asm_r, cnt_r, s_data);
    case (state_r)
      ST_FILL: begin
        s_ready_s = slot_can_load_s;
        if (s_valid && slot_can_load_s) begin
          if (cnt_r == 2'd3) begin
            load_s      = 1'b1;
            load_data_s = word_s;
            cnt_nxt     = 2'd0;
            asm_nxt     = '0;
            // A word-aligned end still owes the core an empty final word.
            if (s_last) begin
              state_nxt = ST_PAD;
            end else begin
              state_nxt = ST_FILL;
            end
          end else if (s_last) begin
            load_s      = 1'b1;
            load_data_s = word_s;
            load_last_s = 1'b1;
            load_bnum_s = cnt_r + 2'd1;
            cnt_nxt     = 2'd0;
            asm_nxt     = '0;
            state_nxt   = ST_DRAIN;
          end else begin
            asm_nxt = word_s;
            cnt_nxt = cnt_r + 2'd1;
          end
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_PAD: begin
        if (slot_can_load_s) begin
          load_s      = 1'b1;
          load_data_s = '0;
          load_last_s = 1'b1;
          load_bnum_s = 2'd0;
          state_nxt   = ST_DRAIN;
        end else begin
          state_nxt = ST_PAD;
        end
      end
      ST_DRAIN: begin
        if (slot_accept_s) begin
          if (WAIT_DIGEST) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_FILL;
            len_clr_s = 1'b1;
          end
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_WAIT: begin
        if (k_out_ready) begin
          state_nxt = ST_FILL;
          cnt_nxt   = 2'd0;
          len_clr_s = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt = ST_FILL;
        cnt_nxt   = 2'd0;
        asm_nxt   = '0;
      end
    endcase
  end

`ifdef KECCAK_PACKER_LEN_EN
  logic [LEN_W-1:0] len_r;
  assign msg_bytes = len_r;

  // Saturating count of bytes accepted in the current message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_r <= '0;
    end else if (len_clr_s) begin
      len_r <= '0;
    end else if (fire_s && (len_r != {LEN_W{1'b1}})) begin
      len_r <= len_r + {{(LEN_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_s;
  assign unused_s = fire_s | len_clr_s;
`endif
endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed, table-driven bench for keccak_byte_packer (checks msg_bytes when KECCAK_PACKER_LEN_EN is defined).
module tb_keccak_byte_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] k_in;
  logic        k_in_ready;
  logic        k_is_last;
  logic [1:0]  k_byte_num;
  logic        k_buffer_full = 1'b0;
  logic        k_out_ready = 1'b0;
  logic        busy;
`ifdef KECCAK_PACKER_LEN_EN
  logic [31:0] msg_bytes;
`endif

  int n_cmp = 0;
  int n_err = 0;

  keccak_byte_packer dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .k_in          (k_in),
    .k_in_ready    (k_in_ready),
    .k_is_last     (k_is_last),
    .k_byte_num    (k_byte_num),
    .k_buffer_full (k_buffer_full),
    .k_out_ready   (k_out_ready),
    .busy          (busy)
`ifdef KECCAK_PACKER_LEN_EN
    ,
    .msg_bytes     (msg_bytes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          exp_words;
    logic [31:0] exp_last;
    logic [1:0]  exp_bnum;
    int          bf_at;
    int          bf_cycles;
  } vec_t;

  vec_t  vecs[6];
  string msgs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] model_word(input string m, input int wi);
    int          n;
    logic [31:0] w;
    logic        lst;
    logic [1:0]  bn;
    n = m.len();
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4 * wi + k < n) w[31 - 8 * k -: 8] = m[4 * wi + k];
    end
    lst = (wi == n / 4);
    bn  = lst ? 2'(n % 4) : 2'd0;
    return {w, lst, bn};
  endfunction

  task automatic run_msg(input int v);
    int          n;
    int          bi;
    int          wi;
    int          cyc;
    int          bf_left;
    bit          bf_done;
    bit          holding;
    logic [34:0] held;
    logic [34:0] last_seen;
    n = msgs[v].len();
    bi = 0; wi = 0; cyc = 0; bf_left = 0; bf_done = 0; holding = 0;
    held = '0; last_seen = '0;
    while (wi < vecs[v].exp_words && cyc < 400) begin
      @(negedge clk);
      if (!bf_done && vecs[v].bf_at >= 0 && bi == vecs[v].bf_at) begin
        bf_left = vecs[v].bf_cycles;
        bf_done = 1;
      end
      k_buffer_full = (bf_left > 0);
      if (bf_left > 0) bf_left--;
      s_valid = (bi < n);
      s_data  = (bi < n) ? msgs[v][bi] : 8'h00;
      s_last  = (bi == n - 1);
      #1;
      if (holding) check("hold_stable", 64'({k_in, k_is_last, k_byte_num}), 64'(held));
      if (k_in_ready && k_buffer_full) begin
        check("bp_s_ready", 64'(s_ready), 64'd0);
        holding = 1;
        held = {k_in, k_is_last, k_byte_num};
      end else begin
        holding = 0;
      end
      if (k_in_ready && !k_buffer_full) begin
        check($sformatf("v%0d_word%0d", v, wi), 64'({k_in, k_is_last, k_byte_num}),
              64'(model_word(msgs[v], wi)));
        last_seen = {k_in, k_is_last, k_byte_num};
        wi++;
      end
      if (s_valid && s_ready) bi++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    k_buffer_full = 1'b0;
    check($sformatf("v%0d_nwords", v), 64'(wi), 64'(vecs[v].exp_words));
    check($sformatf("v%0d_nbytes", v), 64'(bi), 64'(n));
    check($sformatf("v%0d_lastword", v), 64'(last_seen),
          64'({vecs[v].exp_last, 1'b1, vecs[v].exp_bnum}));
  endtask

  task automatic check_wait(input int exp_len);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("wait_block", 64'({s_ready, busy, k_in_ready}), 64'(3'b010));
    end
`ifdef KECCAK_PACKER_LEN_EN
    check("msg_bytes", 64'(msg_bytes), 64'(exp_len));
`else
    if (exp_len < 0) check("exp_len", 64'(exp_len), 64'd0);
`endif
    @(negedge clk);
    k_out_ready = 1'b1;
    @(negedge clk);
    k_out_ready = 1'b0;
    #1;
    check("wait_release", 64'({s_ready, busy}), 64'(2'b10));
`ifdef KECCAK_PACKER_LEN_EN
    check("msg_bytes_clr", 64'(msg_bytes), 64'd0);
`endif
  endtask

  initial begin
    msgs[0] = "The quick brown fox jumps over the lazy dog";
    vecs[0] = '{11, 32'h646F_6700, 2'd3, -1, 0};
    msgs[1] = "The quick brown fox jumps over the lazy dog.";
    vecs[1] = '{12, 32'h0000_0000, 2'd0, 10, 5};
    msgs[2] = "abcd";
    vecs[2] = '{2, 32'h0000_0000, 2'd0, -1, 0};
    msgs[3] = "abcdef";
    vecs[3] = '{2, 32'h6566_0000, 2'd2, 2, 5};
    msgs[4] = "xyz";
    vecs[4] = '{1, 32'h7879_7A00, 2'd3, -1, 0};
    msgs[5] = "Hi";
    vecs[5] = '{1, 32'h4869_0000, 2'd2, -1, 0};

    @(negedge clk); #1;
    check("reset_outs", 64'({k_in, k_in_ready, k_is_last, k_byte_num, s_ready, busy}), 64'd0);
    reset = 1'b0;
    #1;
    check("post_reset_ready", 64'({s_ready, busy}), 64'(2'b10));

    for (int v = 0; v < 5; v++) begin
      run_msg(v);
      check_wait(msgs[v].len());
    end

    // Single byte: word visible the cycle after acceptance, then digest wait.
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h61; s_last = 1'b1;
    #1;
    check("a_accept", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    check("a_word", 64'({k_in, k_in_ready, k_is_last, k_byte_num}),
          64'({32'h6100_0000, 1'b1, 1'b1, 2'd1}));
    check_wait(1);

    // Reset in the middle of "Hello, world".
    msgs[4] = "Hello, world";
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = msgs[4][i]; s_last = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("mid_msg_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset_outs", 64'({k_in, k_in_ready, k_is_last, k_byte_num, s_ready, busy}), 64'd0);
`ifdef KECCAK_PACKER_LEN_EN
    check("midreset_len", 64'(msg_bytes), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_release", 64'({s_ready, busy}), 64'(2'b10));
    run_msg(5);
    check_wait(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
